jtoutrun_subarb: RTL

JTOUTRUN_SUBARB -- requirements
Module: jtoutrun_subarb

---
 rtl/jtoutrun_pkg.sv | 21 ++
 rtl/jtoutrun_subarb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/jtoutrun_pkg.sv
// Shared definitions for the Out Run main/sub CPU bus arbiter.
package jtoutrun_pkg;

  // Default grant timeout in REQ cycles and minimum idle gap after a release
  localparam int TMO_DEF  = 255;
  localparam int HOLD_DEF = 1;

  // Width of the grant and hold counters
  localparam int CNT_W = 8;

  // Arbiter states
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAITBUS,
    ACCESS,
    DONE,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/jtoutrun_subarb.sv
// Lets the main CPU borrow the sub 68000 bus: requests the bus, waits for the
// grant and a free bus, runs one access on the shared target, then hands the
// bus back. Grant timeouts return 16'hFFFF and set a sticky error flag.
module jtoutrun_subarb
  import jtoutrun_pkg::*;
#(
  parameter int TMO  = TMO_DEF,
  parameter int HOLD = HOLD_DEF
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        main_req,
  input  logic [17:0] main_addr,
  input  logic [1:0]  main_dsn,
  input  logic        main_rnw,
  input  logic [15:0] main_dout,
  output logic [15:0] main_din,
  output logic        main_ok,
  output logic        sub_br_n,
  input  logic        sub_bg_n,
  input  logic        sub_as_n,
  output logic        sub_bgack_n,
  output logic        bus_sel,
  output logic        tgt_cs,
  output logic [17:0] tgt_addr,
  output logic [1:0]  tgt_dsn,
  output logic        tgt_rnw,
  output logic [15:0] tgt_dout,
  input  logic [15:0] tgt_din,
  input  logic        tgt_ok,
  output logic        tmo_err
);

  localparam logic [CNT_W:0]   TMO_LIM = (CNT_W+1)'(TMO);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_t       state;
  logic [CNT_W-1:0] grant_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W:0]   grant_next;

  // One extra bit so the comparison against TMO cannot wrap
  assign grant_next = {1'b0, grant_cnt} + {1'b0, ONE};

  // Arbiter FSM with all outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_cnt   <= '0;
      hold_cnt    <= '0;
      sub_br_n    <= 1'b1;
      sub_bgack_n <= 1'b1;
      bus_sel     <= 1'b0;
      tgt_cs      <= 1'b0;
      main_ok     <= 1'b0;
      main_din    <= '0;
      tgt_addr    <= '0;
      tgt_dsn     <= '0;
      tgt_rnw     <= 1'b0;
      tgt_dout    <= '0;
      tmo_err     <= 1'b0;
    end else begin
      main_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - ONE;
          end else if (main_req) begin
            state     <= REQ;
            sub_br_n  <= 1'b0;
            grant_cnt <= '0;
          end
        end
        REQ: begin
          if (!main_req) begin
            state    <= RELEASE;
            sub_br_n <= 1'b1;
          end else if (!sub_bg_n) begin
            state <= WAITBUS;
          end else if (grant_next >= TMO_LIM) begin
            grant_cnt <= TMO_LIM[CNT_W-1:0];
            tmo_err   <= 1'b1;
            main_din  <= 16'hFFFF;
            main_ok   <= 1'b1;
            sub_br_n  <= 1'b1;
            state     <= RELEASE;
          end else begin
            grant_cnt <= grant_next[CNT_W-1:0];
          end
        end
        WAITBUS: begin
          if (!main_req) begin
            state    <= RELEASE;
            sub_br_n <= 1'b1;
          end else if (sub_as_n && !sub_bg_n) begin
            state       <= ACCESS;
            sub_bgack_n <= 1'b0;
            bus_sel     <= 1'b1;
            sub_br_n    <= 1'b1;
            tgt_addr    <= main_addr;
            tgt_dsn     <= main_dsn;
            tgt_rnw     <= main_rnw;
            tgt_dout    <= main_dout;
          end
        end
        ACCESS: begin
          if (tgt_cs && tgt_ok) begin
            tgt_cs  <= 1'b0;
            main_ok <= main_req;
            if (tgt_rnw) main_din <= tgt_din;
            state   <= DONE;
          end else begin
            tgt_cs <= 1'b1;
          end
        end
        DONE: begin
          sub_bgack_n <= 1'b1;
          bus_sel     <= 1'b0;
          state       <= RELEASE;
        end
        RELEASE: begin
          sub_br_n    <= 1'b1;
          sub_bgack_n <= 1'b1;
          bus_sel     <= 1'b0;
          tgt_cs      <= 1'b0;
          hold_cnt    <= HOLD_LD;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
